// File: rtl/ins_pkg.sv
// Instruction-format constants and loader state type shared by the loader and the decoder.
package ins_pkg;

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 16;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHi,
    StWaitLo,
    StWrite,
    StDone,
    StError
  } state_e;

  function automatic logic opc_defined(input logic [OPC_W-1:0] opc);
    return opc <= OP_SUBI;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Byte-pair packer: captures high then low byte and presents the 16-bit instruction word.
module word_packer
  import ins_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              want_hi_i,
  input  logic              want_lo_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              hi_acc_o,
  output logic              word_valid_o,
  output logic [DATA_W-1:0] word_o
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;

  always_comb begin
    hi_acc_o     = rx_valid_i & want_hi_i;
    word_valid_o = rx_valid_i & want_lo_i;
    hi_d         = hi_acc_o ? rx_data_i : hi_q;
    lo_d         = word_valid_o ? rx_data_i : lo_q;
    word_o       = {hi_q, lo_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: packs a byte stream into instruction words, writes program memory, releases CPU.
// Optional build macro PROG_LOADER_OPCHECK_EN rejects opcodes above OP_SUBI instead of writing them.
module prog_loader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OPC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              pm_we_o,
  output logic [ADDR_W-1:0] pm_addr_o,
  output logic [DATA_W-1:0] pm_wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  import ins_pkg::*;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [ADDR_W:0]   CntMax  = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              pm_we_q, pm_we_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              hi_acc;
  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic [OPC_W-1:0]  opc;
  logic              is_hlt;
  logic              opc_bad;

  word_packer u_word_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .want_hi_i    (state_q == StWaitHi),
    .want_lo_i    (state_q == StWaitLo),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .hi_acc_o     (hi_acc),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Opcode is stable from the high-byte accept onward, so it can gate pm_we entering WRITE.
  always_comb begin
    opc    = word[DATA_W-1 -: OPC_W];
    is_hlt = (opc == OP_HLT);
`ifdef PROG_LOADER_OPCHECK_EN
    opc_bad = !opc_defined(opc);
`else
    opc_bad = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d = StWaitHi;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      StWaitHi: if (hi_acc) state_d = StWaitLo;
      StWaitLo: if (word_valid) state_d = StWrite;
      StWrite: begin
        if (opc_bad) begin
          state_d = StError;
        end else begin
          // Address and count saturate rather than wrap.
          if (addr_q != AddrMax) addr_d = addr_q + 1'b1;
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (is_hlt) begin
            state_d = StDone;
          end else if (addr_q == AddrMax) begin
            state_d = StError;
          end else begin
            state_d = StWaitHi;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    rx_ready_d = state_d inside {StWaitHi, StWaitLo};
    busy_d     = state_d inside {StWaitHi, StWaitLo, StWrite};
    pm_we_d    = (state_d == StWrite) & ~opc_bad;
    cpu_run_d  = (state_d == StDone);
    err_d      = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      rx_ready_q <= 1'b0;
      pm_we_q    <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready_d;
      pm_we_q    <= pm_we_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign pm_we_o    = pm_we_q;
  assign pm_addr_o  = addr_q;
  assign pm_wdata_o = word;
  assign cpu_run_o  = cpu_run_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default-width instance A plus an ADDR_W=3 instance B.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sel, start, rx_valid, log_clr;
  logic [7:0] rx_data;

  logic        a_rx_ready, a_pm_we, a_cpu_run, a_busy, a_err;
  logic [10:0] a_pm_addr;
  logic [15:0] a_pm_wdata;
  logic [11:0] a_word_cnt;

  logic        b_rx_ready, b_pm_we, b_cpu_run, b_busy, b_err;
  logic [2:0]  b_pm_addr;
  logic [15:0] b_pm_wdata;
  logic [3:0]  b_word_cnt;

  logic a_start, b_start, a_valid, b_valid, ready_cur;
  assign a_start   = start & ~sel;
  assign b_start   = start & sel;
  assign a_valid   = rx_valid & ~sel;
  assign b_valid   = rx_valid & sel;
  assign ready_cur = sel ? b_rx_ready : a_rx_ready;

  prog_loader u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (a_start),
    .rx_data_i  (rx_data),
    .rx_valid_i (a_valid),
    .rx_ready_o (a_rx_ready),
    .pm_we_o    (a_pm_we),
    .pm_addr_o  (a_pm_addr),
    .pm_wdata_o (a_pm_wdata),
    .cpu_run_o  (a_cpu_run),
    .busy_o     (a_busy),
    .err_o      (a_err),
    .word_cnt_o (a_word_cnt)
  );

  prog_loader #(.ADDR_W(3)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (b_start),
    .rx_data_i  (rx_data),
    .rx_valid_i (b_valid),
    .rx_ready_o (b_rx_ready),
    .pm_we_o    (b_pm_we),
    .pm_addr_o  (b_pm_addr),
    .pm_wdata_o (b_pm_wdata),
    .cpu_run_o  (b_cpu_run),
    .busy_o     (b_busy),
    .err_o      (b_err),
    .word_cnt_o (b_word_cnt)
  );

  int          errors = 0;
  int          checks = 0;
  int          wr_n = 0;
  int          b_wr_n = 0;
  logic        overlap = 1'b0;
  logic [10:0] wr_addr [16];
  logic [15:0] wr_data [16];
  logic [2:0]  b_last_addr = '0;
  logic [15:0] b_last_data = '0;

  // Write log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (log_clr) begin
      wr_n    = 0;
      b_wr_n  = 0;
      overlap = 1'b0;
    end else begin
      if (a_pm_we) begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = a_pm_addr;
          wr_data[wr_n] = a_pm_wdata;
        end
        wr_n++;
        if (a_rx_ready) overlap = 1'b1;
      end
      if (b_pm_we) begin
        b_last_addr = b_pm_addr;
        b_last_data = b_pm_wdata;
        b_wr_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (ready_cur) begin
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      rx_valid = 1'b0;
      check("send_timeout_ready", 32'(ready_cur), 1);
    end
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input int gap);
    send_byte(hi, gap);
    send_byte(lo, gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(negedge clk);
    #1;
    log_clr = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_prog3(input string tag);
    check({tag, "_wr_n"}, wr_n, 3);
    check({tag, "_addr0"}, 32'(wr_addr[0]), 0);
    check({tag, "_data0"}, 32'(wr_data[0]), 'h1805);
    check({tag, "_addr1"}, 32'(wr_addr[1]), 1);
    check({tag, "_data1"}, 32'(wr_data[1]), 'h2803);
    check({tag, "_addr2"}, 32'(wr_addr[2]), 2);
    check({tag, "_data2"}, 32'(wr_data[2]), 'h0000);
    check({tag, "_overlap"}, 32'(overlap), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    sel      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    log_clr  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(a_rx_ready), 0);
    check("rst_pm_we", 32'(a_pm_we), 0);
    check("rst_pm_addr", 32'(a_pm_addr), 0);
    check("rst_pm_wdata", 32'(a_pm_wdata), 0);
    check("rst_cpu_run", 32'(a_cpu_run), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_err", 32'(a_err), 0);
    check("rst_word_cnt", 32'(a_word_cnt), 0);
    check("rst_b_word_cnt", 32'(b_word_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;

    // Basic program: LDI 5, ADDI 3, HLT.
    pulse_start();
    check("t1_busy", 32'(a_busy), 1);
    check("t1_rx_ready", 32'(a_rx_ready), 1);
    send_word(8'h18, 8'h05, 0);
    check("t1_we_after_lo", 32'(a_pm_we), 1);
    check("t1_ready_in_write", 32'(a_rx_ready), 0);
    send_word(8'h28, 8'h03, 0);
    send_word(8'h00, 8'h00, 0);
    check("t1_we_hlt", 32'(a_pm_we), 1);
    check("t1_run_early", 32'(a_cpu_run), 0);
    wait_cycles(1);
    check("t1_cpu_run", 32'(a_cpu_run), 1);
    check("t1_busy_done", 32'(a_busy), 0);
    check("t1_word_cnt", 32'(a_word_cnt), 3);
    check("t1_err", 32'(a_err), 0);
    check_prog3("t1");

    // Restart from DONE, then same program with random gaps.
    clear_log();
    pulse_start();
    check("t2_run_drop", 32'(a_cpu_run), 0);
    check("t2_busy", 32'(a_busy), 1);
    check("t2_word_cnt", 32'(a_word_cnt), 0);
    check("t2_pm_addr", 32'(a_pm_addr), 0);
    send_word(8'h18, 8'h05, int'($urandom_range(5, 0)));
    send_word(8'h28, 8'h03, int'($urandom_range(5, 0)));
    send_word(8'h00, 8'h00, int'($urandom_range(5, 0)));
    wait_cycles(2);
    check("t2_cpu_run", 32'(a_cpu_run), 1);
    check("t2_word_cnt", 32'(a_word_cnt), 3);
    check_prog3("t2");

    // start during WAIT_LO must be ignored.
    clear_log();
    pulse_start();
    send_byte(8'h18, 0);
    pulse_start();
    check("t3_busy", 32'(a_busy), 1);
    check("t3_rx_ready", 32'(a_rx_ready), 1);
    send_byte(8'h05, 0);
    send_word(8'h00, 8'h00, 0);
    wait_cycles(2);
    check("t3_wr_n", wr_n, 2);
    check("t3_addr0", 32'(wr_addr[0]), 0);
    check("t3_data0", 32'(wr_data[0]), 'h1805);
    check("t3_addr1", 32'(wr_addr[1]), 1);
    check("t3_data1", 32'(wr_data[1]), 'h0000);
    check("t3_word_cnt", 32'(a_word_cnt), 2);

    // Undefined opcode 0x1F.
    clear_log();
    pulse_start();
    send_word(8'hF8, 8'h00, 0);
    wait_cycles(2);
`ifdef PROG_LOADER_OPCHECK_EN
    check("t4_err", 32'(a_err), 1);
    check("t4_word_cnt", 32'(a_word_cnt), 0);
    check("t4_wr_n", wr_n, 0);
    check("t4_busy", 32'(a_busy), 0);
    check("t4_cpu_run", 32'(a_cpu_run), 0);
`else
    check("t4_err", 32'(a_err), 0);
    check("t4_word_cnt", 32'(a_word_cnt), 1);
    check("t4_wr_n", wr_n, 1);
    check("t4_addr0", 32'(wr_addr[0]), 0);
    check("t4_data0", 32'(wr_data[0]), 'hF800);
    check("t4_busy", 32'(a_busy), 1);
    send_word(8'h00, 8'h00, 0);
    wait_cycles(2);
    check("t4_cpu_run", 32'(a_cpu_run), 1);
    check("t4_addr1", 32'(wr_addr[1]), 1);
`endif

    // Reset after the first high byte.
    clear_log();
    pulse_start();
    send_byte(8'h3F, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(a_busy), 0);
    check("t5_rst_ready", 32'(a_rx_ready), 0);
    check("t5_rst_wdata", 32'(a_pm_wdata), 0);
    check("t5_rst_cpu_run", 32'(a_cpu_run), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_word(8'h18, 8'h05, 0);
    send_word(8'h00, 8'h00, 0);
    wait_cycles(2);
    check("t5_wr_n", wr_n, 2);
    check("t5_addr0", 32'(wr_addr[0]), 0);
    check("t5_data0", 32'(wr_data[0]), 'h1805);
    check("t5_err", 32'(a_err), 0);
    check("t5_cpu_run", 32'(a_cpu_run), 1);

    // ADDR_W=3: eight ADD words fill memory without HLT.
    clear_log();
    sel = 1'b1;
    pulse_start();
    check("t6_busy", 32'(b_busy), 1);
    for (int i = 0; i < 8; i++) send_word(8'h20, 8'(i), 0);
    check("t6_we_last", 32'(b_pm_we), 1);
    check("t6_addr_last", 32'(b_pm_addr), 7);
    wait_cycles(1);
    check("t6_err", 32'(b_err), 1);
    check("t6_cpu_run", 32'(b_cpu_run), 0);
    check("t6_busy_end", 32'(b_busy), 0);
    check("t6_word_cnt", 32'(b_word_cnt), 8);
    check("t6_wr_n", b_wr_n, 8);
    check("t6_last_addr", 32'(b_last_addr), 7);
    check("t6_last_data", 32'(b_last_data), 'h2007);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
